gray_ptr_counter: RTL and testbench

- Registered up/down binary counter that presents its value as a Gray code pointer.
- Feeds the downstream Gray-to-binary converter, for example on FIFO read/write pointers that cross into other logic.
- Gray output is registered directly from flops, so it is glitch-free and changes by at most one bit per count step.
- Also exposes the binary value and a wrap pulse for local use.

---
 rtl/gray_ptr_counter_if.sv | 48 ++++
 rtl/gray_ptr_counter.sv | 97 +++++++++
 tb/tb_gray_ptr_counter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_ptr_counter_if.sv
// gray_ptr_counter_if
// Groups the control inputs and pointer outputs of gray_ptr_counter.
// Clock and reset are not part of this interface; they stay plain ports.
//
// Signals (all driven by the master except where noted):
//   clr      - synchronous clear to zero
//   load     - synchronous load of load_val
//   load_val - binary value loaded when load=1 (WIDTH bits)
//   en       - count enable, one step per cycle
//   up       - direction, 1 = increment, 0 = decrement
//   gray     - registered Gray pointer (driven by slave)
//   bin      - registered binary count (driven by slave)
//   wrap     - one-cycle pulse on modular wrap (driven by slave)
//   step_err - sticky Gray step violation flag (driven by slave), present
//              only when GRAY_PTR_COUNTER_STEP_CHECK_EN is defined
//
// Modports: master (the user of the pointer), slave (the counter).
interface gray_ptr_counter_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             wrap;
`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
  logic             step_err;
`endif

  modport master (
    output clr, load, load_val, en, up,
    input  gray, bin, wrap
`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
    , input step_err
`endif
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output gray, bin, wrap
`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
    , output step_err
`endif
  );
endinterface

// File: rtl/gray_ptr_counter.sv
// gray_ptr_counter
// Registered up/down binary counter that presents its value as a Gray code
// pointer. Both the binary count and the Gray pointer come straight from
// flops, so the Gray output is glitch-free and moves by one bit per count
// step. A one-cycle wrap pulse marks modular wraps in either direction.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - gray_ptr_counter_if.slave (clr, load, load_val, en, up in;
//           gray, bin, wrap and optionally step_err out)
//
// Parameters:
//   WIDTH - pointer width in bits (>= 1)
//
// Optional feature macro: GRAY_PTR_COUNTER_STEP_CHECK_EN
//   When defined, adds a sticky step_err flag that sets if a counting step
//   ever changes more than or fewer than one Gray bit. Cleared by clr/reset.
module gray_ptr_counter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_ptr_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  // Next count with priority clr > load > en > hold. The Gray value is
  // computed from next_bin so the gray flops load on the same edge as bin
  // instead of being decoded from the bin flops afterwards.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (bus.clr) begin
      bin_next = '0;
    end else if (bus.load) begin
      bin_next = bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        bin_next  = bin_q + ONE;
        wrap_next = (bin_q == ALL_ONES);
      end else begin
        bin_next  = bin_q - ONE;
        wrap_next = (bin_q == '0);
      end
    end
    gray_next = bin_next ^ (bin_next >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.gray = gray_q;
  assign bus.wrap = wrap_q;

`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
  logic count_step;
  logic step_err_q;

  // Only pure counting steps are checked; clr and load may legally move
  // many bits at once. gray_q still holds the previous pointer at the edge.
  assign count_step = !bus.clr && !bus.load && bus.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err_q <= 1'b0;
    end else if (bus.clr) begin
      step_err_q <= 1'b0;
    end else if (count_step && !$onehot(gray_next ^ gray_q)) begin
      step_err_q <= 1'b1;
    end
  end

  assign bus.step_err = step_err_q;
`endif

endmodule

// File: tb/tb_gray_ptr_counter.sv
// tb_gray_ptr_counter
// Self-checking bench for gray_ptr_counter at WIDTH=4, with an extra
// WIDTH=8 instance exercising the step checker when
// GRAY_PTR_COUNTER_STEP_CHECK_EN is defined. Expected values come from a
// behavioural model using modular arithmetic and a reflected Gray table.
module tb_gray_ptr_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_ptr_counter_if #(.WIDTH(W)) bus ();
  gray_ptr_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
  gray_ptr_counter_if #(.WIDTH(8)) bus8 ();
  gray_ptr_counter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   m_bin;
  logic m_wrap;
  int   gray_tab [0:255];

  // Reflected Gray construction: each doubling mirrors the list so far and
  // sets the new top bit on the mirrored half.
  task automatic build_gray_table();
    int size;
    gray_tab[0] = 0;
    size = 1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < size; i++)
        gray_tab[size + i] = gray_tab[size - 1 - i] | size;
      size = size * 2;
    end
  endtask

  // Drives one clock cycle of controls, advances the model, and returns at
  // posedge + 1 so outputs are sampled away from the edge.
  task automatic cycle(input logic c, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic u);
    bus.clr = c; bus.load = l; bus.load_val = lv; bus.en = e; bus.up = u;
    @(posedge clk);
    if (c) begin
      m_bin = 0; m_wrap = 1'b0;
    end else if (l) begin
      m_bin = int'(lv); m_wrap = 1'b0;
    end else if (e) begin
      if (u) begin
        m_wrap = (m_bin == MAX);
        m_bin  = (m_bin + 1) % (MAX + 1);
      end else begin
        m_wrap = (m_bin == 0);
        m_bin  = (m_bin + MAX) % (MAX + 1);
      end
    end else begin
      m_wrap = 1'b0;
    end
    #1;
    bus.clr = 1'b0; bus.load = 1'b0; bus.en = 1'b0; bus.up = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.bin !== 4'h0 || bus.gray !== 4'h0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial: got bin=%h gray=%h wrap=%b, expected 0/0/0",
               bus.bin, bus.gray, bus.wrap);
    end
    rst_n = 1'b1;
    m_bin = 0; m_wrap = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (bus.bin !== 4'h6) begin
      errors++;
      $display("[TB] FAIL reset_precount: got bin=%h, expected 6", bus.bin);
    end
    // Assert reset mid-cycle and look before any clock edge arrives
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.bin !== 4'h0 || bus.gray !== 4'h0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got bin=%h gray=%h wrap=%b, expected 0/0/0",
               bus.bin, bus.gray, bus.wrap);
    end
    m_bin = 0; m_wrap = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (bus.bin !== 4'h1 || bus.gray !== 4'h1) begin
      errors++;
      $display("[TB] FAIL reset_first_step: got bin=%h gray=%h, expected 1/1",
               bus.bin, bus.gray);
    end
  endtask

  task automatic test_full_up();
    logic [3:0] exp_seq [16];
    logic [3:0] prev_gray;
    exp_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    prev_gray = 4'h0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
      checks++;
      if (bus.gray !== exp_seq[i] || bus.wrap !== (i == 15) || bus.bin !== 4'(m_bin)) begin
        errors++;
        $display("[TB] FAIL full_up[%0d]: got gray=%h wrap=%b bin=%h, expected gray=%h wrap=%b bin=%h",
                 i, bus.gray, bus.wrap, bus.bin, exp_seq[i], (i == 15), 4'(m_bin));
      end
      checks++;
      if ($countones(bus.gray ^ prev_gray) != 1) begin
        errors++;
        $display("[TB] FAIL full_up_onebit[%0d]: got %0d bits changed, expected 1",
                 i, $countones(bus.gray ^ prev_gray));
      end
      prev_gray = bus.gray;
    end
  endtask

  task automatic test_down_wrap();
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.bin !== 4'hF || bus.gray !== 4'h8 || bus.wrap !== 1'b1) begin
      errors++;
      $display("[TB] FAIL down_wrap: got bin=%h gray=%h wrap=%b, expected F/8/1",
               bus.bin, bus.gray, bus.wrap);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.bin !== 4'hE || bus.gray !== 4'h9 || bus.wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL down_after_wrap: got bin=%h gray=%h wrap=%b, expected E/9/0",
               bus.bin, bus.gray, bus.wrap);
    end
  endtask

  task automatic test_load();
    cycle(1'b0, 1'b1, 4'hA, 1'b1, 1'b1);
    checks++;
    if (bus.bin !== 4'hA || bus.gray !== 4'hF || bus.wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load: got bin=%h gray=%h wrap=%b, expected A/F/0",
               bus.bin, bus.gray, bus.wrap);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'h3, 1'b0, 1'b1);
      checks++;
      if (bus.bin !== 4'hA || bus.gray !== 4'hF || bus.wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold[%0d]: got bin=%h gray=%h wrap=%b, expected A/F/0",
                 i, bus.bin, bus.gray, bus.wrap);
      end
    end
  endtask

  task automatic test_priority();
    cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
    checks++;
    if (bus.bin !== 4'h0 || bus.gray !== 4'h0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL priority_clr: got bin=%h gray=%h wrap=%b, expected 0/0/0",
               bus.bin, bus.gray, bus.wrap);
    end
    // load beats en: from all-ones, load+en up must not wrap
    cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'h5, 1'b1, 1'b1);
    checks++;
    if (bus.bin !== 4'h5 || bus.gray !== 4'h7 || bus.wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL priority_load: got bin=%h gray=%h wrap=%b, expected 5/7/0",
               bus.bin, bus.gray, bus.wrap);
    end
  endtask

  task automatic test_random();
    logic c, l, e, u;
    logic [W-1:0] lv;
    for (int i = 0; i < 300; i++) begin
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1);
      lv = W'($urandom);
      cycle(c, l, lv, e, u);
      checks++;
      if (bus.bin !== W'(m_bin) || bus.gray !== W'(gray_tab[m_bin]) || bus.wrap !== m_wrap) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got bin=%h gray=%h wrap=%b, expected bin=%h gray=%h wrap=%b",
                 i, bus.bin, bus.gray, bus.wrap, W'(m_bin), W'(gray_tab[m_bin]), m_wrap);
      end
    end
  endtask

`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
  task automatic test_step_check();
    int mb;
    logic l, e, u;
    logic [7:0] lv;
    mb = 0;
    bus8.clr = 1'b1; bus8.load = 1'b0; bus8.en = 1'b0; bus8.up = 1'b0; bus8.load_val = '0;
    @(posedge clk); #1;
    bus8.clr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      l  = ($urandom_range(0, 15) == 0);
      e  = $urandom_range(0, 1);
      u  = $urandom_range(0, 1);
      lv = 8'($urandom);
      bus8.load = l; bus8.load_val = lv; bus8.en = e; bus8.up = u;
      @(posedge clk);
      if (l) mb = int'(lv);
      else if (e) mb = u ? (mb + 1) % 256 : (mb + 255) % 256;
      #1;
      checks++;
      if (bus8.bin !== 8'(mb) || bus8.gray !== 8'(gray_tab[mb]) || bus8.step_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL step_random[%0d]: got bin=%h gray=%h step_err=%b, expected bin=%h gray=%h step_err=0",
                 i, bus8.bin, bus8.gray, bus8.step_err, 8'(mb), 8'(gray_tab[mb]));
      end
    end
    bus8.en = 1'b0;
    bus8.load = 1'b1; bus8.load_val = 8'h00;
    @(posedge clk); #1;
    bus8.load_val = 8'h05;
    @(posedge clk); #1;
    bus8.load = 1'b0;
    checks++;
    if (bus8.gray !== 8'h07 || bus8.step_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL step_load_jump: got gray=%h step_err=%b, expected 07/0",
               bus8.gray, bus8.step_err);
    end
  endtask
`endif

  initial begin
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0; bus.up = 1'b0;
`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
    bus8.clr = 1'b0; bus8.load = 1'b0; bus8.load_val = '0; bus8.en = 1'b0; bus8.up = 1'b0;
`endif
    build_gray_table();
    $display("[TB] starting gray_ptr_counter bench");
    test_reset();
    test_full_up();
    test_down_wrap();
    test_load();
    test_priority();
    test_random();
`ifdef GRAY_PTR_COUNTER_STEP_CHECK_EN
    test_step_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
